// File: rtl/vga_timing_pkg.sv
// Shared types and constants for the VGA timing generator.
//   timing_t         : one complete set of h/v timing fields plus sync polarities
//   timing_fields_ok : true when all eight timing fields are nonzero
//   DEF_*            : default 800x480 timing
package vga_timing_pkg;

  // Fields are stored at a fixed maximum width. Modules zero-extend their
  // CNT_W-wide values into them and use only the low CNT_W bits.
  localparam int MAX_CNT_W = 16;

  typedef logic [MAX_CNT_W-1:0] tfield_t;

  typedef struct packed {
    tfield_t h_sync, h_back, h_vis, h_front;
    tfield_t v_sync, v_back, v_vis, v_front;
    logic    hs_pol, vs_pol;
  } timing_t;

  localparam int DEF_H_SYNC  = 88;
  localparam int DEF_H_BACK  = 47;
  localparam int DEF_H_VIS   = 800;
  localparam int DEF_H_FRONT = 40;
  localparam int DEF_V_SYNC  = 3;
  localparam int DEF_V_BACK  = 31;
  localparam int DEF_V_VIS   = 480;
  localparam int DEF_V_FRONT = 13;

  function automatic logic timing_fields_ok(input timing_t t);
    return (t.h_sync != '0) && (t.h_back != '0) && (t.h_vis != '0) && (t.h_front != '0) &&
           (t.v_sync != '0) && (t.v_back != '0) && (t.v_vis != '0) && (t.v_front != '0);
  endfunction

endpackage

// File: rtl/vga_sig_delay.sv
// Enable-gated delay line of DEPTH register stages. DEPTH=0 is a pass-through.
//   gclk, grst_n : clock, async active-low reset (stages reset to RST_VAL)
//   en           : stages shift only while high, otherwise they hold
//   din / dout   : W-bit input and output delayed by DEPTH enabled cycles
module vga_sig_delay #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctl;
    assign unused_ctl = ^{gclk, grst_n, en};
    assign dout = din;
  end else begin : g_pipe
    logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;

    always_comb begin
      pipe_d = pipe_q;
      if (en) begin
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
      end
    end

    always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) pipe_q <= {DEPTH{RST_VAL}};
      else         pipe_q <= pipe_d;
    end

    assign dout = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator with frame-synchronous config update.
//   vga_clk, reset_n      : pixel clock, async active-low reset
//   enable                : counters and pipeline advance only while high
//   cfg_* / cfg_load      : new timing, captured into a shadow on cfg_load
//   cfg_pending / cfg_err : shadow awaits frame boundary / load had a zero field
//   pixel_x/y, de         : active coordinate and area flag
//   hs, vs, blank_n       : syncs and blanking, PIPE_DLY enabled cycles after de
//   line_start/frame_start: one-cycle pulses at h_cnt==0 / h_cnt==v_cnt==0
// All outputs are registered and describe the counter value present one
// cycle earlier, so the first enabled cycle after reset shows frame_start.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CNT_W    = 12,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_VIS    = DEF_H_VIS,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_VIS    = DEF_V_VIS,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int PIPE_DLY = 2
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] cfg_h_sync,
  input  logic [CNT_W-1:0] cfg_h_back,
  input  logic [CNT_W-1:0] cfg_h_vis,
  input  logic [CNT_W-1:0] cfg_h_front,
  input  logic [CNT_W-1:0] cfg_v_sync,
  input  logic [CNT_W-1:0] cfg_v_back,
  input  logic [CNT_W-1:0] cfg_v_vis,
  input  logic [CNT_W-1:0] cfg_v_front,
  input  logic             cfg_hs_pol,
  input  logic             cfg_vs_pol,
  input  logic             cfg_load,
  output logic             cfg_pending,
  output logic             cfg_err,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             de,
  output logic             hs,
  output logic             vs,
  output logic             blank_n,
  output logic             line_start,
  output logic             frame_start
);

  // Two guard bits keep sync+back+vis+front from wrapping.
  localparam int SW = CNT_W + 2;

  localparam timing_t RST_TIM = '{
    h_sync: tfield_t'(H_SYNC), h_back: tfield_t'(H_BACK),
    h_vis:  tfield_t'(H_VIS),  h_front: tfield_t'(H_FRONT),
    v_sync: tfield_t'(V_SYNC), v_back: tfield_t'(V_BACK),
    v_vis:  tfield_t'(V_VIS),  v_front: tfield_t'(V_FRONT),
    hs_pol: 1'(HS_POL),        vs_pol: 1'(VS_POL)};

  // Delay-line reset holds syncs inactive and blank_n low.
  localparam logic [2:0] DLY_RST = {HS_POL == 0, VS_POL == 0, 1'b0};

  function automatic logic [SW-1:0] fx(input tfield_t f);
    return {2'b00, f[CNT_W-1:0]};
  endfunction

  timing_t          act_q, act_d, shd_q, shd_d, cfg_in;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] px_q, px_d, py_q, py_d;
  logic             pend_q, pend_d, err_q, err_d;
  logic             de_q, de_d, hs_r_q, hs_r_d, vs_r_q, vs_r_d;
  logic             ls_q, ls_d, fs_q, fs_d;
  logic [SW-1:0]    h_ext, v_ext, h_lo, h_hi, h_end, v_lo, v_hi, v_end, h_off, v_off;
  logic             h_last, v_last, de_raw;
  logic [2:0]       dly_out;

  // Upper field bits beyond CNT_W are never consulted.
  logic unused_act;
  assign unused_act = ^act_q;

  always_comb begin
    cfg_in = '{
      h_sync: tfield_t'(cfg_h_sync), h_back: tfield_t'(cfg_h_back),
      h_vis:  tfield_t'(cfg_h_vis),  h_front: tfield_t'(cfg_h_front),
      v_sync: tfield_t'(cfg_v_sync), v_back: tfield_t'(cfg_v_back),
      v_vis:  tfield_t'(cfg_v_vis),  v_front: tfield_t'(cfg_v_front),
      hs_pol: cfg_hs_pol,            vs_pol: cfg_vs_pol};

    h_ext  = {2'b00, h_cnt_q};
    v_ext  = {2'b00, v_cnt_q};
    h_lo   = fx(act_q.h_sync) + fx(act_q.h_back);
    h_hi   = h_lo + fx(act_q.h_vis);
    h_end  = h_hi + fx(act_q.h_front) - SW'(1);
    v_lo   = fx(act_q.v_sync) + fx(act_q.v_back);
    v_hi   = v_lo + fx(act_q.v_vis);
    v_end  = v_hi + fx(act_q.v_front) - SW'(1);
    h_last = (h_ext == h_end);
    v_last = (v_ext == v_end);
    h_off  = h_ext - h_lo;
    v_off  = v_ext - v_lo;
    de_raw = (h_ext >= h_lo) && (h_ext < h_hi) && (v_ext >= v_lo) && (v_ext < v_hi);

    // Counters
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (enable) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end

    // Config: the boundary consumes the old shadow first, so a load in the
    // same cycle lands in the shadow and stays pending for the next frame.
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    err_d  = 1'b0;
    if (enable && h_last && v_last && pend_q) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
    if (cfg_load) begin
      if (timing_fields_ok(cfg_in)) begin
        shd_d  = cfg_in;
        pend_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    // Output stage: hold while disabled, pulses drop to zero.
    de_d   = de_q;
    hs_r_d = hs_r_q;
    vs_r_d = vs_r_q;
    px_d   = px_q;
    py_d   = py_q;
    ls_d   = 1'b0;
    fs_d   = 1'b0;
    if (enable) begin
      de_d   = de_raw;
      hs_r_d = ~((h_ext < fx(act_q.h_sync)) ^ act_q.hs_pol);
      vs_r_d = ~((v_ext < fx(act_q.v_sync)) ^ act_q.vs_pol);
      if (de_raw) begin
        px_d = h_off[CNT_W-1:0];
        py_d = v_off[CNT_W-1:0];
      end
      ls_d = (h_cnt_q == '0);
      fs_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      act_q   <= RST_TIM;
      shd_q   <= RST_TIM;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      de_q    <= 1'b0;
      hs_r_q  <= DLY_RST[2];
      vs_r_q  <= DLY_RST[1];
      px_q    <= '0;
      py_q    <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      de_q    <= de_d;
      hs_r_q  <= hs_r_d;
      vs_r_q  <= vs_r_d;
      px_q    <= px_d;
      py_q    <= py_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  vga_sig_delay #(.W(3), .DEPTH(PIPE_DLY), .RST_VAL(DLY_RST)) u_dly (
    .gclk   (vga_clk),
    .grst_n (reset_n),
    .en     (enable),
    .din    ({hs_r_q, vs_r_q, de_q}),
    .dout   (dly_out)
  );

  assign {hs, vs, blank_n} = dly_out;
  assign de          = de_q;
  assign pixel_x     = px_q;
  assign pixel_y     = py_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign cfg_pending = pend_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: two instances share stimulus, one with PIPE_DLY=0 and one
// with PIPE_DLY=3, both at small timing 2/2/4/2 (HT=10) and 1/1/3/1 (VT=6).
module tb_vga_timing_gen;
  localparam int CW = 12;

  logic vga_clk = 1'b0, reset_n = 1'b0, enable = 1'b0, cfg_load = 1'b0;
  logic [CW-1:0] c_hs = '0, c_hb = '0, c_hv = '0, c_hf = '0;
  logic [CW-1:0] c_vs = '0, c_vb = '0, c_vv = '0, c_vf = '0;
  logic c_hp = 1'b1, c_vp = 1'b1;

  logic pend0, err0, de0, hs0, vs0, bl0, ls0, fs0;
  logic [CW-1:0] px0, py0;
  logic pend3, err3, de3, hs3, vs3, bl3, ls3, fs3;
  logic [CW-1:0] px3, py3;

  int checks = 0, errors = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(.CNT_W(CW), .H_SYNC(2), .H_BACK(2), .H_VIS(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_VIS(3), .V_FRONT(1), .HS_POL(1), .VS_POL(1),
    .PIPE_DLY(0)) dut0 (
    .vga_clk(vga_clk), .reset_n(reset_n), .enable(enable),
    .cfg_h_sync(c_hs), .cfg_h_back(c_hb), .cfg_h_vis(c_hv), .cfg_h_front(c_hf),
    .cfg_v_sync(c_vs), .cfg_v_back(c_vb), .cfg_v_vis(c_vv), .cfg_v_front(c_vf),
    .cfg_hs_pol(c_hp), .cfg_vs_pol(c_vp), .cfg_load(cfg_load),
    .cfg_pending(pend0), .cfg_err(err0), .pixel_x(px0), .pixel_y(py0), .de(de0),
    .hs(hs0), .vs(vs0), .blank_n(bl0), .line_start(ls0), .frame_start(fs0));

  vga_timing_gen #(.CNT_W(CW), .H_SYNC(2), .H_BACK(2), .H_VIS(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_VIS(3), .V_FRONT(1), .HS_POL(1), .VS_POL(1),
    .PIPE_DLY(3)) dut3 (
    .vga_clk(vga_clk), .reset_n(reset_n), .enable(enable),
    .cfg_h_sync(c_hs), .cfg_h_back(c_hb), .cfg_h_vis(c_hv), .cfg_h_front(c_hf),
    .cfg_v_sync(c_vs), .cfg_v_back(c_vb), .cfg_v_vis(c_vv), .cfg_v_front(c_vf),
    .cfg_hs_pol(c_hp), .cfg_vs_pol(c_vp), .cfg_load(cfg_load),
    .cfg_pending(pend3), .cfg_err(err3), .pixel_x(px3), .pixel_y(py3), .de(de3),
    .hs(hs3), .vs(vs3), .blank_n(bl3), .line_start(ls3), .frame_start(fs3));

  // Hand-derived expectations for the 10x6 frame, index p = v*10 + h.
  function automatic logic de_small(input int p);
    int h = p % 10;
    int v = p / 10;
    return (h >= 4) && (h < 8) && (v >= 2) && (v < 5);
  endfunction

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic set_cfg(input int hs_, hb, hv, hf, vs_, vb, vv, vf);
    c_hs = CW'(hs_); c_hb = CW'(hb); c_hv = CW'(hv); c_hf = CW'(hf);
    c_vs = CW'(vs_); c_vb = CW'(vb); c_vv = CW'(vv); c_vf = CW'(vf);
    c_hp = 1'b1; c_vp = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    checks++;
    if ({de0, bl0, hs0, vs0, ls0, fs0, pend0, err0, px0, py0} !== '0) begin
      errors++;
      $display("FAIL reset_dut0 got %b %b %b %b %b %b %b %b %0d %0d exp all 0",
               de0, bl0, hs0, vs0, ls0, fs0, pend0, err0, px0, py0);
    end
    checks++;
    if ({de3, bl3, hs3, vs3, ls3, fs3, pend3, err3, px3, py3} !== '0) begin
      errors++;
      $display("FAIL reset_dut3 got %b %b %b %b %b %b exp all 0", de3, bl3, hs3, vs3, ls3, fs3);
    end
    reset_n = 1'b1; enable = 1'b1;
  endtask

  task automatic test_small_timing();
    for (int p = 0; p < 60; p++) begin
      int h = p % 10;
      int v = p / 10;
      logic e;
      tick();
      e = de_small(p);
      checks++;
      if ({de0, hs0, vs0, bl0, ls0, fs0} !== {e, h < 2, v < 1, e, h == 0, p == 0}) begin
        errors++;
        $display("FAIL small_p%0d de/hs/vs/bl/ls/fs got %b%b%b%b%b%b exp %b%b%b%b%b%b", p,
                 de0, hs0, vs0, bl0, ls0, fs0, e, h < 2, v < 1, e, h == 0, p == 0);
      end
      if (e) begin
        checks++;
        if (px0 !== CW'(h - 4) || py0 !== CW'(v - 2)) begin
          errors++;
          $display("FAIL small_pix_p%0d got %0d,%0d exp %0d,%0d", p, px0, py0, h - 4, v - 2);
        end
      end
    end
  endtask

  // Second frame: previous-frame history is valid, so index p-3 wraps.
  task automatic test_pipe_delay();
    for (int p = 0; p < 60; p++) begin
      int q = (p + 57) % 60;
      tick();
      checks++;
      if ({de3, bl3, hs3, vs3} !== {de_small(p), de_small(q), (q % 10) < 2, (q / 10) < 1}) begin
        errors++;
        $display("FAIL dly3_p%0d de/bl/hs/vs got %b%b%b%b exp %b%b%b%b", p, de3, bl3, hs3, vs3,
                 de_small(p), de_small(q), (q % 10) < 2, (q / 10) < 1);
      end
    end
  endtask

  task automatic test_enable_hold();
    logic [31:0] snap;
    int n;
    repeat (26) tick();  // now at h=5, v=2
    checks++;
    if (de0 !== 1'b1 || px0 !== CW'(1) || py0 !== CW'(0)) begin
      errors++;
      $display("FAIL hold_pre got de=%b px=%0d py=%0d exp 1,1,0", de0, px0, py0);
    end
    snap = {de0, hs0, vs0, bl0, de3, hs3, vs3, bl3, px0, py0};
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if ({de0, hs0, vs0, bl0, de3, hs3, vs3, bl3, px0, py0} !== snap ||
          {ls0, fs0, ls3, fs3} !== 4'b0) begin
        errors++;
        $display("FAIL hold_%0d got %h ls/fs %b%b exp %h 00", i,
                 {de0, hs0, vs0, bl0, de3, hs3, vs3, bl3, px0, py0}, ls0, fs0, snap);
      end
    end
    enable = 1'b1;
    tick();
    checks++;
    if (px0 !== CW'(2) || de0 !== 1'b1) begin
      errors++;
      $display("FAIL hold_resume got px=%0d de=%b exp 2,1", px0, de0);
    end
    n = 8;
    while (!ls0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 12) begin
      errors++;
      $display("FAIL hold_line_end got %0d cycles exp 12", n);
    end
  endtask

  // Starts at frame index 30 of the 10x6 frame.
  task automatic test_cfg_load();
    set_cfg(3, 3, 3, 3, 1, 1, 3, 1);
    cfg_load = 1'b1;
    tick();  // p=31
    checks++;
    if (pend0 !== 1'b1) begin
      errors++;
      $display("FAIL cfg_pend_first got %b exp 1", pend0);
    end
    set_cfg(1, 1, 2, 1, 1, 1, 3, 1);  // overwrite: last valid load wins
    tick();  // p=32
    cfg_load = 1'b0;
    for (int p = 33; p < 60; p++) begin
      tick();
      checks++;
      if (pend0 !== (p < 59) || fs0 !== 1'b0) begin
        errors++;
        $display("FAIL cfg_pend_p%0d got pend=%b fs=%b exp %b 0", p, pend0, fs0, p < 59);
      end
    end
    tick();
    checks++;
    if (fs0 !== 1'b1 || pend0 !== 1'b0) begin
      errors++;
      $display("FAIL cfg_boundary got fs=%b pend=%b exp 1 0", fs0, pend0);
    end
    // New 5x6 frame: de at h 2..3, v 2..4; hs at h 0.
    for (int j = 1; j <= 30; j++) begin
      int h = j % 5;
      int v = (j / 5) % 6;
      logic e;
      tick();
      e = (h >= 2) && (h < 4) && (v >= 2) && (v < 5);
      checks++;
      if ({ls0, fs0, hs0, de0} !== {h == 0, j == 30, h < 1, e}) begin
        errors++;
        $display("FAIL cfg_new_j%0d ls/fs/hs/de got %b%b%b%b exp %b%b%b%b", j, ls0, fs0, hs0,
                 de0, h == 0, j == 30, h < 1, e);
      end
      if (e) begin
        checks++;
        if (px0 !== CW'(h - 2) || py0 !== CW'(v - 2)) begin
          errors++;
          $display("FAIL cfg_new_pix_j%0d got %0d,%0d exp %0d,%0d", j, px0, py0, h - 2, v - 2);
        end
      end
    end
  endtask

  task automatic test_cfg_err();
    int j;
    set_cfg(1, 1, 1, 1, 1, 1, 0, 1);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    checks++;
    if (err0 !== 1'b1 || pend0 !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse got err=%b pend=%b exp 1 0", err0, pend0);
    end
    tick();
    checks++;
    if (err0 !== 1'b0 || pend0 !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got err=%b pend=%b exp 0 0", err0, pend0);
    end
    j = 2;
    while (!fs0 && j < 100) begin
      tick();
      j++;
    end
    checks++;
    if (j !== 30) begin
      errors++;
      $display("FAIL err_frame_len got %0d exp 30", j);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    set_cfg(1, 1, 2, 1, 1, 1, 3, 1);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    repeat (17) tick();  // 5x6 frame index 18: h=3, v=3
    checks++;
    if (pend0 !== 1'b1 || de0 !== 1'b1 || px0 !== CW'(1) || py0 !== CW'(1)) begin
      errors++;
      $display("FAIL rst_pre got pend=%b de=%b px=%0d py=%0d exp 1 1 1 1", pend0, de0, px0, py0);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({de0, bl0, hs0, vs0, ls0, fs0, pend0, err0, px0, py0, de3, bl3, hs3, vs3} !== '0) begin
      errors++;
      $display("FAIL rst_async got de=%b bl=%b hs=%b vs=%b pend=%b px=%0d py=%0d exp 0",
               de0, bl0, hs0, vs0, pend0, px0, py0);
    end
    repeat (2) @(posedge vga_clk);
    #1 reset_n = 1'b1;
    tick();
    checks++;
    if (fs0 !== 1'b1 || ls0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_first_frame got fs=%b ls=%b exp 1 1", fs0, ls0);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (!ls0 && n < 40);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL rst_line_len got %0d exp 10", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_small_timing();
    test_pipe_delay();
    test_enable_hold();
    test_cfg_load();
    test_cfg_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 12, meaning the width of every counter, coordinate and config field.
REQ-002 SHALL have parameters H_SYNC/H_BACK/H_VIS/H_FRONT, defaults 88/47/800/40, meaning the reset horizontal timing in pixels.
REQ-003 SHALL have parameters V_SYNC/V_BACK/V_VIS/V_FRONT, defaults 3/31/480/13, meaning the reset vertical timing in lines.
REQ-004 SHALL have parameters HS_POL/VS_POL, default 1/1, meaning the reset sync active level.
REQ-005 SHALL have parameter PIPE_DLY, default 2, range 0..7, meaning the delay in cycles of hs/vs/blank_n relative to pixel_x/pixel_y.
REQ-006 SHALL have ports:
 vga_clk  in  1  pixel clock; all logic on rising edge
 reset_n  in  1  asynchronous, active-low reset
 enable  in  1  counters advance only when high
 cfg_h_sync, cfg_h_back, cfg_h_vis, cfg_h_front  in  CNT_W each  new horizontal timing
 cfg_v_sync, cfg_v_back, cfg_v_vis, cfg_v_front  in  CNT_W each  new vertical timing
 cfg_hs_pol, cfg_vs_pol  in  1 each  new sync polarities
 cfg_load  in  1  single-cycle request to capture cfg_*
 cfg_pending  out  1  a captured config awaits frame boundary
 cfg_err  out  1  one-cycle pulse: load rejected
 pixel_x, pixel_y  out  CNT_W each  coordinate of the current active pixel
 de  out  1  undelayed active-area flag, aligned with pixel_x/pixel_y
 hs, vs  out  1 each  syncs at the configured polarity, delayed PIPE_DLY
 blank_n  out  1  de delayed PIPE_DLY
 line_start  out  1  one-cycle pulse when h_cnt==0
 frame_start  out  1  one-cycle pulse when h_cnt==0 and v_cnt==0

Function
REQ-007 SHALL order each line/frame as sync, back porch, visible, front porch; h_cnt 0..HT-1, where HT=sync+back+vis+front (v likewise).
REQ-008 SHALL increment h_cnt each enabled cycle, wrap to 0 at HT-1, increment v_cnt on that wrap, and wrap v_cnt to 0 at VT-1.
REQ-009 SHALL, when enable is low, hold all counters, coordinates, pipeline stages and outputs, and suppress pulses.
REQ-010 SHALL assert the raw hsync when h_cnt<h_sync and the raw vsync when v_cnt<v_sync; the output level SHALL equal raw XNOR pol.
REQ-011 SHALL set de=1 when h_cnt is in [h_sync+h_back, h_sync+h_back+h_vis) and v_cnt is in the corresponding vertical window.
REQ-012 SHALL drive pixel_x=h_cnt-(h_sync+h_back) and pixel_y=v_cnt-(v_sync+v_back) while de=1, and hold the last values while de=0.
REQ-013 SHALL register all outputs, with no combinational path from inputs to outputs.
REQ-014 SHALL delay hs, vs and blank_n by exactly PIPE_DLY enabled cycles after de; PIPE_DLY=0 means same cycle as de.
REQ-015 SHALL, on cfg_load with all eight fields nonzero, capture cfg_* into a shadow register and set cfg_pending the next cycle.
REQ-016 SHALL, on cfg_load with any field zero, pulse cfg_err for one cycle and leave the shadow and cfg_pending unchanged.
REQ-017 SHALL, on a new cfg_load while pending, overwrite the shadow; the last valid load wins.
REQ-018 SHALL copy shadow to active timing on the enabled cycle where h_cnt==HT-1 and v_cnt==VT-1, then clear cfg_pending; the next frame uses the new timing from h_cnt=0.
REQ-019 SHALL, if cfg_load coincides with the boundary cycle, apply the previously pending shadow and leave the new one pending.
REQ-020 SHALL size counter compares at CNT_W+2 bits so that sums of fields never overflow; totals above 2^CNT_W-1 are unsupported.

Reset
REQ-021 SHALL, while reset_n=0, set h_cnt=v_cnt=0, active and shadow timing to the parameters, cfg_pending=cfg_err=0, de=blank_n=0, pixel_x=pixel_y=0, line_start=frame_start=0, and hs/vs to their inactive level.
REQ-022 SHALL clear pipeline stages to the inactive level; release SHALL start at frame_start on the first enabled cycle.

Structure
REQ-023 SHALL place the timing-field record type, the zero-check function and the default timing constants in package vga_timing_pkg.
REQ-024 SHALL implement the PIPE_DLY delay line as sub-module vga_sig_delay (width and depth parameters, enable hold).

Verification
REQ-025 SHALL test small timing 2/2/4/2 H and 1/1/3/1 V with PIPE_DLY=0: de high for h_cnt 4..7 on v_cnt 2..4, pixel_x 0..3, pixel_y 0..2, HT=10, VT=6.
REQ-026 SHALL test PIPE_DLY=3: blank_n equals de shifted 3 cycles; hs is high for h_cnt 3..4 when HS_POL=1.
REQ-027 SHALL test cfg_load of 1/1/2/1 mid-frame: cfg_pending=1 until the boundary, and the next frame_start follows a 5-cycle line period.
REQ-028 SHALL test cfg_load with cfg_v_vis=0: cfg_err pulses once, cfg_pending stays 0, and timing is unchanged.
REQ-029 SHALL test enable low for 7 cycles mid-line: all outputs are frozen, and the line completes 7 cycles later.
REQ-030 SHALL test reset_n asserted mid-frame: outputs take reset values asynchronously, and frame_start occurs on the first cycle after release.
